// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// One grant per cycle; enables and data are registered toward the array.
module reg_write_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREG-1:0]       wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  pend_valid,
  output logic [AW-1:0]         pend_addr
);

  localparam int unsigned PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned ZERO_IDX = NREG - 1;

  logic [PW-1:0]    rr_ptr_q,     rr_ptr_d;
  logic [NREG-1:0]  wr_en_q,      wr_en_d;
  logic [WIDTH-1:0] wr_data_q,    wr_data_d;
  logic             pend_valid_q, pend_valid_d;
  logic [AW-1:0]    pend_addr_q,  pend_addr_d;

  logic [AW-1:0]    addr_a [NREQ];
  logic [WIDTH-1:0] data_a [NREQ];

  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic [NREQ-1:0]  ack_c;
  logic [31:0]      scan_idx;
  logic [AW-1:0]    grant_addr;
  logic             grant_real;

  // Unpack the flattened request buses
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      data_a[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or after rr_ptr (wrapping) wins; nothing while reset/stall
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    ack_c     = '0;
    if (!reset && !stall) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = (32'(rr_ptr_q) + k) % NREQ;
        if (!grant_vld && req[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(scan_idx);
        end
      end
    end
    if (grant_vld) begin
      ack_c = NREQ'(1) << grant_idx;
    end
  end

  assign ack = ack_c;

  // Zero register and out-of-range indices are consumed without an enable
  always_comb begin
    grant_addr = addr_a[grant_idx];
    grant_real = (32'(grant_addr) < ZERO_IDX);
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_en_d      = '0;
    wr_data_d    = wr_data_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    if (grant_vld) begin
      rr_ptr_d    = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);
      wr_data_d   = data_a[grant_idx];
      pend_addr_d = grant_addr;
      if (grant_real) begin
        wr_en_d      = NREG'(1) << grant_addr;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      wr_en_q      <= '0;
      wr_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;

endmodule
